// File: rtl/shift_pkg.sv
// Shared types and constants for the pipelined shift unit.
// Holds shift_op_e, XLEN, SHAMT_W and the bit_rev helper.
package shift_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } shift_op_e;

  function automatic logic [XLEN-1:0] bit_rev(
    input logic [XLEN-1:0] x
  );
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) begin
      r[i] = x[XLEN-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational barrel level: right shift or rotate by K.
// Ports: d_i operand, en_i apply level, fill_i shifted-in bit,
//   rot_i rotate instead of shift, q_o result.
module shift_level
  import shift_pkg::*;
#(
  parameter int K = 1
) (
  input  logic [XLEN-1:0] d_i,
  input  logic            en_i,
  input  logic            fill_i,
  input  logic            rot_i,
  output logic [XLEN-1:0] q_o
);

  logic [XLEN-1:0] shr;
  logic [XLEN-1:0] ror;

  assign shr = {{K{fill_i}}, d_i[XLEN-1:K]};
  assign ror = {d_i[K-1:0], d_i[XLEN-1:K]};

  always_comb begin
    q_o = d_i;
    if (en_i) begin
      q_o = rot_i ? ror : shr;
    end
  end

endmodule

// File: rtl/shift_pipe_32bit.sv
// Two-stage pipelined SLL/SRL/SRA shifter with tag and
// valid/ready on both sides; flush_i kills in-flight work.
// Ports: clk_i, rst_i (async high), flush_i,
//   valid_i/ready_o/op_i/data_i/shamt_i/tag_i upstream,
//   valid_o/ready_i/data_o/tag_o downstream.
// Macro ROTATE_EN: op 11 rotates right; else it is SRL.
// S1_LVLS must lie in 1..4.
module shift_pipe_32bit
  import shift_pkg::*;
#(
  parameter int TAG_W   = 5,
  parameter int S1_LVLS = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [1:0]         op_i,
  input  logic [XLEN-1:0]    data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [TAG_W-1:0]   tag_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [XLEN-1:0]    data_o,
  output logic [TAG_W-1:0]   tag_o
);

  localparam int HI_W = SHAMT_W - S1_LVLS;

  shift_op_e op_in;
  assign op_in = shift_op_e'(op_i);

  // stage 1 state
  logic              s1_valid_q, s1_valid_d;
  shift_op_e         s1_op_q, s1_op_d;
  logic [XLEN-1:0]   s1_data_q, s1_data_d;
  logic [HI_W-1:0]   s1_shamt_q, s1_shamt_d;
  logic              s1_fill_q, s1_fill_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;

  // stage 2 state
  logic              s2_valid_q, s2_valid_d;
  logic [XLEN-1:0]   s2_data_q, s2_data_d;
  logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;

  logic s2_ld;
  logic s1_ld;
  logic s1_take;
  logic s2_take;

  // Handshake: ready_o follows ready_i combinationally.
  assign s2_ld   = !s2_valid_q || ready_i;
  assign s1_ld   = !s1_valid_q || s2_ld;
  assign ready_o = !flush_i && s1_ld;
  assign s1_take = valid_i && ready_o;
  assign s2_take = s2_ld && s1_valid_q;

  // Stage 1 datapath. SLL runs as reverse/SRL/reverse
  // so every barrel level only shifts right.
  logic rot1;
  logic rot2;
  logic fill1;

`ifdef ROTATE_EN
  assign rot1 = (op_in == SH_ROR);
  assign rot2 = (s1_op_q == SH_ROR);
`else
  assign rot1 = 1'b0;
  assign rot2 = 1'b0;
`endif

  // Sign bit is taken from the original operand.
  assign fill1 = (op_in == SH_SRA) && data_i[XLEN-1];

  logic [XLEN-1:0] c1 [S1_LVLS+1];
  assign c1[0] = (op_in == SH_SLL) ? bit_rev(data_i) : data_i;

  for (genvar g = 0; g < S1_LVLS; g++) begin : g_s1
    shift_level #(.K(1 << g)) u_lvl (
      .d_i    (c1[g]),
      .en_i   (shamt_i[g]),
      .fill_i (fill1),
      .rot_i  (rot1),
      .q_o    (c1[g+1])
    );
  end

  // Stage 2 datapath: remaining levels, then undo SLL reversal.
  logic [XLEN-1:0] c2 [HI_W+1];
  assign c2[0] = s1_data_q;

  for (genvar g = 0; g < HI_W; g++) begin : g_s2
    shift_level #(.K(1 << (g + S1_LVLS))) u_lvl (
      .d_i    (c2[g]),
      .en_i   (s1_shamt_q[g]),
      .fill_i (s1_fill_q),
      .rot_i  (rot2),
      .q_o    (c2[g+1])
    );
  end

  logic [XLEN-1:0] res2;
  assign res2 = (s1_op_q == SH_SLL) ? bit_rev(c2[HI_W]) : c2[HI_W];

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_data_d  = s1_data_q;
    s1_shamt_d = s1_shamt_q;
    s1_fill_d  = s1_fill_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_tag_d   = s2_tag_q;

    if (s1_ld) begin
      s1_valid_d = s1_take;
    end
    if (s1_take) begin
      s1_op_d    = op_in;
      s1_data_d  = c1[S1_LVLS];
      s1_shamt_d = shamt_i[SHAMT_W-1:S1_LVLS];
      s1_fill_d  = fill1;
      s1_tag_d   = tag_i;
    end

    if (s2_ld) begin
      s2_valid_d = s1_valid_q;
    end
    // Only load real entries so data_o holds its last value.
    if (s2_take) begin
      s2_data_d = res2;
      s2_tag_d  = s1_tag_q;
    end

    if (flush_i) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= SH_SLL;
      s1_data_q  <= '0;
      s1_shamt_q <= '0;
      s1_fill_q  <= 1'b0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_data_q  <= s1_data_d;
      s1_shamt_q <= s1_shamt_d;
      s1_fill_q  <= s1_fill_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  assign valid_o = s2_valid_q;
  assign data_o  = s2_data_q;
  assign tag_o   = s2_tag_q;

endmodule

// File: tb/tb_shift_pipe_32bit.sv
// Directed bench for shift_pipe_32bit: vector table plus
// back-to-back, backpressure, flush and reset sequences.
module tb_shift_pipe_32bit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic [1:0]  op_i;
  logic [31:0] data_i;
  logic [4:0]  shamt_i;
  logic [4:0]  tag_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] data_o;
  logic [4:0]  tag_o;

  shift_pipe_32bit #(.TAG_W(5), .S1_LVLS(3)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .op_i    (op_i),
    .data_i  (data_i),
    .shamt_i (shamt_i),
    .tag_i   (tag_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .tag_o   (tag_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  typedef struct {
    string       nm;
    logic [1:0]  op;
    logic [31:0] d;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[14];

  task automatic drive(input logic v, input logic [1:0] op,
                       input logic [31:0] d, input logic [4:0] sh,
                       input logic [4:0] tg);
    valid_i = v;
    op_i    = op;
    data_i  = d;
    shamt_i = sh;
    tag_i   = tg;
  endtask

  task automatic run_vec(input vec_t v, input logic [4:0] tg);
    @(negedge clk_i);
    drive(1'b1, v.op, v.d, v.sh, tg);
    chk({v.nm, "_rdy"}, {31'b0, ready_o}, 32'd1);
    @(negedge clk_i);
    drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
    chk({v.nm, "_early"}, {31'b0, valid_o}, 32'd0);
    @(negedge clk_i);
    chk({v.nm, "_vld"}, {31'b0, valid_o}, 32'd1);
    chk({v.nm, "_data"}, data_o, v.exp);
    chk({v.nm, "_tag"}, {27'b0, tag_o}, {27'b0, tg});
  endtask

  initial begin
    vt[0]  = '{"srl4",    2'b01, 32'hF000_0000, 5'd4,  32'h0F00_0000};
    vt[1]  = '{"sra31",   2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
    vt[2]  = '{"sll31",   2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000};
    vt[3]  = '{"srl0",    2'b01, 32'h1234_5678, 5'd0,  32'h1234_5678};
    vt[4]  = '{"sra8",    2'b10, 32'h8765_4321, 5'd8,  32'hFF87_6543};
    vt[5]  = '{"sll12",   2'b00, 32'h1234_5678, 5'd12, 32'h4567_8000};
    vt[6]  = '{"sra_pos", 2'b10, 32'h7000_0000, 5'd4,  32'h0700_0000};
    vt[7]  = '{"srl31",   2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001};
    vt[8]  = '{"sll16",   2'b00, 32'hFFFF_FFFF, 5'd16, 32'hFFFF_0000};
    vt[9]  = '{"sra0",    2'b10, 32'hF000_0000, 5'd0,  32'hF000_0000};
`ifdef ROTATE_EN
    vt[10] = '{"op3_4",   2'b11, 32'h0000_00F1, 5'd4,  32'h1000_000F};
    vt[11] = '{"op3_1",   2'b11, 32'h8000_0001, 5'd1,  32'hC000_0000};
`else
    vt[10] = '{"op3_4",   2'b11, 32'h0000_00F1, 5'd4,  32'h0000_000F};
    vt[11] = '{"op3_1",   2'b11, 32'h8000_0001, 5'd1,  32'h4000_0000};
`endif
    vt[12] = '{"srl1",    2'b01, 32'hAAAA_AAAA, 5'd1,  32'h5555_5555};
    vt[13] = '{"sra1",    2'b10, 32'hAAAA_AAAA, 5'd1,  32'hD555_5555};

    rst_i   = 1'b1;
    flush_i = 1'b0;
    ready_i = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
    #12;
    chk("rst_valid", {31'b0, valid_o}, 32'd0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_tag", {27'b0, tag_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("rst_ready", {31'b0, ready_o}, 32'd1);

    for (int i = 0; i < 14; i++) begin
      run_vec(vt[i], 5'(i + 1));
    end

    // back-to-back: 4 requests, results in consecutive cycles
    for (int c = 0; c < 7; c++) begin
      @(negedge clk_i);
      if (c >= 2 && c < 6) begin
        chk($sformatf("b2b_vld%0d", c), {31'b0, valid_o}, 32'd1);
        chk($sformatf("b2b_tag%0d", c), {27'b0, tag_o}, 32'(c - 1));
        chk($sformatf("b2b_dat%0d", c), data_o, 32'(c * 16 - 32));
      end else begin
        chk($sformatf("b2b_idle%0d", c), {31'b0, valid_o}, 32'd0);
      end
      if (c < 4) begin
        drive(1'b1, 2'b01, 32'(c * 16), 5'd0, 5'(c + 1));
        chk($sformatf("b2b_rdy%0d", c), {31'b0, ready_o}, 32'd1);
      end else begin
        drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
      end
    end

    // backpressure: ready_i low for cycles 0..3
    @(negedge clk_i);
    ready_i = 1'b0;
    drive(1'b1, 2'b00, 32'h0000_0003, 5'd1, 5'd5);
    chk("bp_rdy0", {31'b0, ready_o}, 32'd1);
    @(negedge clk_i);
    drive(1'b1, 2'b01, 32'h0000_0030, 5'd4, 5'd6);
    chk("bp_rdy1", {31'b0, ready_o}, 32'd1);
    @(negedge clk_i);
    drive(1'b1, 2'b10, 32'h8000_0000, 5'd3, 5'd7);
    chk("bp_rdy2", {31'b0, ready_o}, 32'd0);
    chk("bp_vld2", {31'b0, valid_o}, 32'd1);
    chk("bp_dat2", data_o, 32'h0000_0006);
    @(negedge clk_i);
    chk("bp_rdy3", {31'b0, ready_o}, 32'd0);
    chk("bp_dat3", data_o, 32'h0000_0006);
    chk("bp_tag3", {27'b0, tag_o}, 32'd5);
    @(negedge clk_i);
    ready_i = 1'b1;
    #1;
    chk("bp_rdy4", {31'b0, ready_o}, 32'd1);
    chk("bp_tag4", {27'b0, tag_o}, 32'd5);
    @(negedge clk_i);
    drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
    chk("bp_tag5", {27'b0, tag_o}, 32'd6);
    chk("bp_dat5", data_o, 32'h0000_0003);
    @(negedge clk_i);
    chk("bp_tag6", {27'b0, tag_o}, 32'd7);
    chk("bp_dat6", data_o, 32'hF000_0000);
    @(negedge clk_i);
    chk("bp_empty", {31'b0, valid_o}, 32'd0);

    // flush with both stages full and a request offered
    @(negedge clk_i);
    drive(1'b1, 2'b01, 32'h0000_0100, 5'd0, 5'd10);
    @(negedge clk_i);
    drive(1'b1, 2'b01, 32'h0000_0200, 5'd0, 5'd11);
    @(negedge clk_i);
    drive(1'b1, 2'b01, 32'h0000_0300, 5'd0, 5'd12);
    flush_i = 1'b1;
    #1;
    chk("fl_vld", {31'b0, valid_o}, 32'd1);
    chk("fl_tag", {27'b0, tag_o}, 32'd10);
    chk("fl_rdy", {31'b0, ready_o}, 32'd0);
    @(negedge clk_i);
    flush_i = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
    chk("fl_kill", {31'b0, valid_o}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk($sformatf("fl_gone%0d", c), {31'b0, valid_o}, 32'd0);
    end

    // async reset with an entry in stage 2
    @(negedge clk_i);
    drive(1'b1, 2'b01, 32'h0000_00AB, 5'd0, 5'd20);
    ready_i = 1'b0;
    @(negedge clk_i);
    drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
    @(negedge clk_i);
    chk("ar_vld", {31'b0, valid_o}, 32'd1);
    chk("ar_dat", data_o, 32'h0000_00AB);
    #1 rst_i = 1'b1;
    #1;
    chk("ar_clr", {31'b0, valid_o}, 32'd0);
    chk("ar_dat0", data_o, 32'd0);
    @(negedge clk_i);
    rst_i   = 1'b0;
    ready_i = 1'b1;
    @(negedge clk_i);
    chk("ar_stay", {31'b0, valid_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
